// File: rtl/ethernet_header_pkg.sv
// Shared Ethernet header types and constants for the receive-side parser.
// Byte index 0 of each header field holds the first byte seen on the wire.
package ethernet_header_pkg;

    localparam int          ETH_HEADER_BYTES = 14;
    localparam int          ETH_MAX_LENGTH   = 1500;
    localparam logic [47:0] ETH_BROADCAST    = 48'hffff_ffff_ffff;

    typedef struct packed {
        logic [5:0][7:0] mac_destination;
        logic [5:0][7:0] mac_source;
        logic [1:0][7:0] eth_type_length;
    } ethernet_header;

    // Wire order is most-significant byte first, so byte 0 lands in [47:40].
    function automatic logic [47:0] mac_value(input logic [5:0][7:0] bytes);
        logic [47:0] v;
        v = '0;
        for (int k = 0; k < 6; k++) begin
            v = {v[39:0], bytes[k]};
        end
        return v;
    endfunction

    function automatic logic [15:0] type_value(input logic [1:0][7:0] bytes);
        return {bytes[0], bytes[1]};
    endfunction

endpackage

// File: rtl/eth_mac_filter.sv
// Destination-address filter: accepts our own station address, broadcast,
// or anything at all when promiscuous.
module eth_mac_filter
    import ethernet_header_pkg::*;
#(
    parameter logic [47:0] MY_MAC      = 48'he86a64e7e830,
    parameter logic        PROMISCUOUS = 1'b0
) (
    input  logic [5:0][7:0] destination_i,
    output logic            accept_o
);

    logic [47:0] dest_value;

    assign dest_value = mac_value(destination_i);
    assign accept_o   = PROMISCUOUS
                     || (dest_value == MY_MAC)
                     || (dest_value == ETH_BROADCAST);

endmodule

// File: rtl/eth_header_parse.sv
// Receive-side Ethernet header parser: captures the 14-byte header, filters on
// destination and forwards payload of accepted frames with one cycle latency.
module eth_header_parse
    import ethernet_header_pkg::*;
#(
    parameter logic [47:0] MY_MAC      = 48'he86a64e7e830,
    parameter logic        PROMISCUOUS = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [7:0]     in_data,
    input  logic           in_valid,
    input  logic           in_last,
    output ethernet_header output_header,
    output logic           header_valid,
    output logic           mac_match,
    output logic [7:0]     out_data,
    output logic           out_valid,
    output logic           out_last,
    output logic           err_runt,
    output logic           err_length,
    output logic [15:0]    drop_count
);

    typedef enum logic [1:0] {
        ST_HEADER,
        ST_PAYLOAD,
        ST_DISCARD
    } state_t;

    localparam logic [3:0]  LAST_HDR_IDX = 4'(ETH_HEADER_BYTES - 1);
    localparam logic [15:0] MAX_LEN      = 16'(ETH_MAX_LENGTH);

    state_t           state_q, state_d;
    logic [3:0]       byte_cnt_q, byte_cnt_d;
    logic [10:0]      pay_cnt_q, pay_cnt_d;
    logic [13:0][7:0] hdr_bytes_q, hdr_bytes_d;
    logic             header_valid_q, header_valid_d;
    logic             mac_match_q, mac_match_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             err_runt_q, err_runt_d;
    logic             err_length_q, err_length_d;
    logic [15:0]      drop_count_q, drop_count_d;

    logic             accept;
    logic [10:0]      pay_cnt_inc;
    logic [15:0]      len_payload;
    logic [15:0]      len_hdr_only;

    always_comb begin
        output_header = '0;
        for (int k = 0; k < 6; k++) begin
            output_header.mac_destination[k] = hdr_bytes_q[k];
            output_header.mac_source[k]      = hdr_bytes_q[k + 6];
        end
        for (int k = 0; k < 2; k++) begin
            output_header.eth_type_length[k] = hdr_bytes_q[k + 12];
        end
    end

    // Destination bytes are complete long before byte 13, so the captured copy is safe to use.
    eth_mac_filter #(
        .MY_MAC      (MY_MAC),
        .PROMISCUOUS (PROMISCUOUS)
    ) u_filter (
        .destination_i (output_header.mac_destination),
        .accept_o      (accept)
    );

    assign pay_cnt_inc  = (pay_cnt_q == 11'h7ff) ? pay_cnt_q : pay_cnt_q + 11'd1;
    assign len_payload  = type_value(output_header.eth_type_length);
    // On a header-only frame the second length byte is still on in_data.
    assign len_hdr_only = {hdr_bytes_q[12], in_data};

    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        pay_cnt_d      = pay_cnt_q;
        hdr_bytes_d    = hdr_bytes_q;
        header_valid_d = 1'b0;
        mac_match_d    = mac_match_q;
        out_data_d     = out_data_q;
        out_valid_d    = 1'b0;
        out_last_d     = 1'b0;
        err_runt_d     = 1'b0;
        err_length_d   = 1'b0;
        drop_count_d   = drop_count_q;

        if (in_valid) begin
            unique case (state_q)
                ST_HEADER: begin
                    hdr_bytes_d[byte_cnt_q] = in_data;
                    if (byte_cnt_q == LAST_HDR_IDX) begin
                        byte_cnt_d     = 4'd0;
                        pay_cnt_d      = 11'd0;
                        header_valid_d = 1'b1;
                        mac_match_d    = accept;
                        if (!accept) begin
                            drop_count_d = drop_count_q + 16'd1;
                        end
                        if (in_last) begin
                            state_d      = ST_HEADER;
                            err_length_d = accept && (len_hdr_only != 16'd0)
                                                  && (len_hdr_only <= MAX_LEN);
                        end else begin
                            state_d = accept ? ST_PAYLOAD : ST_DISCARD;
                        end
                    end else if (in_last) begin
                        err_runt_d = 1'b1;
                        byte_cnt_d = 4'd0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end
                ST_PAYLOAD: begin
                    out_data_d  = in_data;
                    out_valid_d = 1'b1;
                    out_last_d  = in_last;
                    pay_cnt_d   = pay_cnt_inc;
                    if (in_last) begin
                        state_d      = ST_HEADER;
                        err_length_d = (len_payload <= MAX_LEN)
                                    && ({5'd0, pay_cnt_inc} < len_payload);
                    end
                end
                ST_DISCARD: begin
                    if (in_last) begin
                        state_d = ST_HEADER;
                    end
                end
                default: begin
                    state_d = ST_HEADER;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_HEADER;
            byte_cnt_q     <= '0;
            pay_cnt_q      <= '0;
            hdr_bytes_q    <= '0;
            header_valid_q <= 1'b0;
            mac_match_q    <= 1'b0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            err_runt_q     <= 1'b0;
            err_length_q   <= 1'b0;
            drop_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            pay_cnt_q      <= pay_cnt_d;
            hdr_bytes_q    <= hdr_bytes_d;
            header_valid_q <= header_valid_d;
            mac_match_q    <= mac_match_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            out_last_q     <= out_last_d;
            err_runt_q     <= err_runt_d;
            err_length_q   <= err_length_d;
            drop_count_q   <= drop_count_d;
        end
    end

    assign header_valid = header_valid_q;
    assign mac_match    = mac_match_q;
    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;
    assign err_runt     = err_runt_q;
    assign err_length   = err_length_q;
    assign drop_count   = drop_count_q;

endmodule

// File: tb/tb_eth_header_parse.sv
// Bench for eth_header_parse: a filtering and a promiscuous instance share one
// input stream; a frame-level model predicts headers, payload and error pulses.
module tb_eth_header_parse;
    import ethernet_header_pkg::*;

    localparam logic [47:0] MY    = 48'he86a64e7e830;
    localparam logic [47:0] OTHER = 48'he86a64e7e899;
    localparam logic [47:0] BCAST = 48'hffffffffffff;

    logic clk = 1'b0;
    logic reset, in_valid, in_last;
    logic [7:0] in_data;

    ethernet_header hdr0, hdr1;
    logic hv0, hv1, mm0, mm1, ov0, ov1, ol0, ol1, er0, er1, el0, el1;
    logic [7:0]  od0, od1;
    logic [15:0] dc0, dc1;

    eth_header_parse #(.MY_MAC(MY), .PROMISCUOUS(1'b0)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .output_header(hdr0), .header_valid(hv0), .mac_match(mm0),
        .out_data(od0), .out_valid(ov0), .out_last(ol0),
        .err_runt(er0), .err_length(el0), .drop_count(dc0));

    eth_header_parse #(.MY_MAC(MY), .PROMISCUOUS(1'b1)) dut_p (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .output_header(hdr1), .header_valid(hv1), .mac_match(mm1),
        .out_data(od1), .out_valid(ov1), .out_last(ol1),
        .err_runt(er1), .err_length(el1), .drop_count(dc1));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Observations
    logic [8:0]     got0[$], got1[$];
    int             gcyc0[$], len_cyc0[$], runt_cyc0[$];
    int             hv_n[2], runt_n[2], len_n[2];
    logic           mm_at[2];
    ethernet_header hdr_at[2];

    // Expectations
    logic [8:0]     exp_q0[$], exp_q1[$];
    int             exp_hv[2], exp_runt[2], exp_len[2];
    logic [15:0]    exp_drop[2];
    logic           exp_match[2];
    ethernet_header exp_hdr[2];

    logic [7:0] frame_q[$];
    int         cons_cyc[$];
    int         last_cyc[$];

    always @(negedge clk) begin
        if (ov0) begin got0.push_back({ol0, od0}); gcyc0.push_back(cyc); end
        if (ov1) got1.push_back({ol1, od1});
        if (hv0) begin hv_n[0]++; mm_at[0] = mm0; hdr_at[0] = hdr0; end
        if (hv1) begin hv_n[1]++; mm_at[1] = mm1; hdr_at[1] = hdr1; end
        if (er0) begin runt_n[0]++; runt_cyc0.push_back(cyc); end
        if (er1) runt_n[1]++;
        if (el0) begin len_n[0]++; len_cyc0.push_back(cyc); end
        if (el1) len_n[1]++;
    end

    task automatic clear_mon();
        got0.delete(); got1.delete(); gcyc0.delete(); len_cyc0.delete(); runt_cyc0.delete();
        exp_q0.delete(); exp_q1.delete(); last_cyc.delete();
        for (int i = 0; i < 2; i++) begin
            hv_n[i] = 0; runt_n[i] = 0; len_n[i] = 0;
            exp_hv[i] = 0; exp_runt[i] = 0; exp_len[i] = 0;
        end
    endtask

    task automatic build_frame(input logic [47:0] dst, input logic [15:0] tl, input int npay, input bit seq);
        logic [47:0] src;
        src = {16'($urandom), 32'($urandom)};
        frame_q.delete();
        for (int k = 5; k >= 0; k--) frame_q.push_back(dst[k*8 +: 8]);
        for (int k = 5; k >= 0; k--) frame_q.push_back(src[k*8 +: 8]);
        frame_q.push_back(tl[15:8]);
        frame_q.push_back(tl[7:0]);
        for (int k = 0; k < npay; k++) frame_q.push_back(seq ? 8'(k) : 8'($urandom));
    endtask

    // Frame-level reference: what each instance must report for frame_q.
    task automatic model_frame(input int idx);
        int          n;
        logic [47:0] dest;
        logic [15:0] len;
        bit          acc;
        n = frame_q.size();
        if (n < ETH_HEADER_BYTES) begin exp_runt[idx]++; return; end
        exp_hv[idx]++;
        dest = '0;
        for (int k = 0; k < 6; k++) dest = {dest[39:0], frame_q[k]};
        acc = (idx == 1) || (dest == MY) || (dest == BCAST);
        exp_match[idx] = acc;
        for (int k = 0; k < 6; k++) begin
            exp_hdr[idx].mac_destination[k] = frame_q[k];
            exp_hdr[idx].mac_source[k]      = frame_q[k + 6];
        end
        exp_hdr[idx].eth_type_length[0] = frame_q[12];
        exp_hdr[idx].eth_type_length[1] = frame_q[13];
        if (!acc) begin exp_drop[idx]++; return; end
        len = {frame_q[12], frame_q[13]};
        if (len <= 16'd1500 && (n - 14) < int'(len)) exp_len[idx]++;
        for (int k = 14; k < n; k++) begin
            if (idx == 0) exp_q0.push_back({(k == n - 1), frame_q[k]});
            else          exp_q1.push_back({(k == n - 1), frame_q[k]});
        end
    endtask

    task automatic drive(input bit gaps);
        cons_cyc.delete();
        for (int i = 0; i < frame_q.size(); i++) begin
            in_data = frame_q[i]; in_valid = 1'b1; in_last = (i == frame_q.size() - 1);
            @(posedge clk); #1;
            cons_cyc.push_back(cyc);
            in_valid = 1'b0; in_last = 1'b0; in_data = 8'($urandom);
            if (gaps) begin @(posedge clk); #1; end
        end
        last_cyc.push_back(cons_cyc[cons_cyc.size() - 1]);
    endtask

    task automatic send(input bit gaps);
        $display("frame: %0d bytes, gaps=%0d, first byte %h", frame_q.size(), gaps, frame_q[0]);
        model_frame(0);
        model_frame(1);
        drive(gaps);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        idle(3);
        exp_drop[0] = 16'd0; exp_drop[1] = 16'd0;
        chk_cnt++; if ({hv0, mm0, ov0, ol0, er0, el0} !== 6'b0) $display("FAIL reset_flags0: got %b required 000000", {hv0, mm0, ov0, ol0, er0, el0}); else pass_cnt++;
        chk_cnt++; if ({hv1, mm1, ov1, ol1, er1, el1} !== 6'b0) $display("FAIL reset_flags1: got %b required 000000", {hv1, mm1, ov1, ol1, er1, el1}); else pass_cnt++;
        chk_cnt++; if (od0 !== 8'h00 || dc0 !== 16'h0) $display("FAIL reset_data: out_data %h drop %h required 0", od0, dc0); else pass_cnt++;
        chk_cnt++; if (hdr0 !== '0) $display("FAIL reset_header: got %h required 0", hdr0); else pass_cnt++;
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_unicast();
        int bad = 0;
        clear_mon();
        build_frame(MY, 16'h0800, 46, 1'b1);
        send(1'b0);
        idle(4);
        for (int k = 0; k < exp_q0.size() && k < got0.size(); k++) begin
            if (got0[k] !== exp_q0[k]) bad++;
            if (gcyc0[k] !== cons_cyc[14 + k]) bad++;
        end
        chk_cnt++; if (hv_n[0] !== 1 || mm_at[0] !== 1'b1) $display("FAIL unicast_hv: pulses %0d match %b required 1/1", hv_n[0], mm_at[0]); else pass_cnt++;
        chk_cnt++; if (hdr_at[0] !== exp_hdr[0]) $display("FAIL unicast_header: got %h required %h", hdr_at[0], exp_hdr[0]); else pass_cnt++;
        chk_cnt++; if (got0.size() !== 46) $display("FAIL unicast_count: got %0d bytes required 46", got0.size()); else pass_cnt++;
        chk_cnt++; if (bad !== 0) $display("FAIL unicast_payload: %0d bad bytes/latencies required 0", bad); else pass_cnt++;
        chk_cnt++; if (runt_n[0] + len_n[0] !== 0) $display("FAIL unicast_errors: got %0d required 0", runt_n[0] + len_n[0]); else pass_cnt++;
    endtask

    task automatic test_filter();
        int bad = 0;
        clear_mon();
        build_frame(OTHER, 16'h0800, 30, 1'b0);
        send(1'b0);
        idle(4);
        for (int k = 0; k < exp_q1.size() && k < got1.size(); k++) if (got1[k] !== exp_q1[k]) bad++;
        chk_cnt++; if (hv_n[0] !== 1 || mm_at[0] !== 1'b0) $display("FAIL filter_match: pulses %0d match %b required 1/0", hv_n[0], mm_at[0]); else pass_cnt++;
        chk_cnt++; if (got0.size() !== 0) $display("FAIL filter_forward: got %0d bytes required 0", got0.size()); else pass_cnt++;
        chk_cnt++; if (dc0 !== exp_drop[0]) $display("FAIL filter_drop: got %0d required %0d", dc0, exp_drop[0]); else pass_cnt++;
        chk_cnt++; if (mm_at[1] !== 1'b1 || dc1 !== exp_drop[1]) $display("FAIL promisc_accept: match %b drop %0d required 1/%0d", mm_at[1], dc1, exp_drop[1]); else pass_cnt++;
        chk_cnt++; if (got1.size() !== exp_q1.size() || bad !== 0) $display("FAIL promisc_payload: %0d bytes %0d bad required %0d/0", got1.size(), bad, exp_q1.size()); else pass_cnt++;
    endtask

    task automatic test_gaps();
        int bad = 0;
        clear_mon();
        build_frame(BCAST, 16'h0806, 40, 1'b0);
        send(1'b1);
        idle(4);
        for (int k = 0; k < exp_q0.size() && k < got0.size(); k++) begin
            if (got0[k] !== exp_q0[k]) bad++;
            if (gcyc0[k] !== cons_cyc[14 + k]) bad++;
        end
        chk_cnt++; if (mm_at[0] !== 1'b1) $display("FAIL gaps_bcast_match: got %b required 1", mm_at[0]); else pass_cnt++;
        chk_cnt++; if (got0.size() !== exp_q0.size() || bad !== 0) $display("FAIL gaps_payload: %0d bytes %0d bad required %0d/0", got0.size(), bad, exp_q0.size()); else pass_cnt++;
    endtask

    task automatic test_runt();
        int bad = 0;
        clear_mon();
        build_frame(MY, 16'h0800, 0, 1'b0);
        while (frame_q.size() > 10) void'(frame_q.pop_back());
        send(1'b0);
        build_frame(MY, 16'h0020, 46, 1'b0);
        send(1'b0);
        idle(4);
        for (int k = 0; k < exp_q0.size() && k < got0.size(); k++) if (got0[k] !== exp_q0[k]) bad++;
        chk_cnt++; if (runt_n[0] !== 1) $display("FAIL runt_pulse: got %0d required 1", runt_n[0]); else pass_cnt++;
        chk_cnt++; if (runt_cyc0.size() != 1 || runt_cyc0[0] !== last_cyc[0]) $display("FAIL runt_timing: got %0d pulses, required 1 at cycle %0d", runt_cyc0.size(), last_cyc[0]); else pass_cnt++;
        chk_cnt++; if (hv_n[0] !== 1 || hdr_at[0] !== exp_hdr[0]) $display("FAIL runt_next_header: pulses %0d hdr %h required 1 %h", hv_n[0], hdr_at[0], exp_hdr[0]); else pass_cnt++;
        chk_cnt++; if (got0.size() !== 46 || bad !== 0 || len_n[0] !== 0) $display("FAIL runt_next_payload: %0d bytes %0d bad %0d errs required 46/0/0", got0.size(), bad, len_n[0]); else pass_cnt++;
    endtask

    task automatic test_length();
        clear_mon();
        build_frame(MY, 16'h0040, 50, 1'b0);
        send(1'b0);
        build_frame(MY, 16'h0020, 46, 1'b0);
        send(1'b0);
        build_frame(BCAST, 16'h0010, 0, 1'b0);
        send(1'b0);
        build_frame(MY, 16'h0000, 0, 1'b0);
        send(1'b0);
        idle(4);
        chk_cnt++; if (len_n[0] !== exp_len[0]) $display("FAIL length_count: got %0d required %0d", len_n[0], exp_len[0]); else pass_cnt++;
        chk_cnt++; if (len_cyc0.size() < 1 || len_cyc0[0] !== last_cyc[0]) $display("FAIL length_short_timing: %0d pulses, required one at cycle %0d", len_cyc0.size(), last_cyc[0]); else pass_cnt++;
        chk_cnt++; if (len_cyc0.size() < 2 || len_cyc0[1] !== last_cyc[2]) $display("FAIL length_hdr_only: %0d pulses, required second at cycle %0d", len_cyc0.size(), last_cyc[2]); else pass_cnt++;
        chk_cnt++; if (hv_n[0] !== 4) $display("FAIL length_headers: got %0d required 4", hv_n[0]); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int bad0 = 0, bad1 = 0;
        clear_mon();
        for (int f = 0; f < 20; f++) begin
            logic [47:0] dst;
            logic [15:0] tl;
            int r;
            r   = $urandom_range(0, 3);
            dst = (r == 0) ? MY : (r == 1) ? BCAST : (r == 2) ? OTHER : {16'($urandom), 32'($urandom)};
            tl  = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 80)) : 16'h0800;
            build_frame(dst, tl, $urandom_range(0, 60), 1'b0);
            if ($urandom_range(0, 4) == 0) begin
                r = $urandom_range(1, 13);
                while (frame_q.size() > r) void'(frame_q.pop_back());
            end
            send($urandom_range(0, 3) == 0);
        end
        idle(4);
        for (int k = 0; k < exp_q0.size() && k < got0.size(); k++) if (got0[k] !== exp_q0[k]) bad0++;
        for (int k = 0; k < exp_q1.size() && k < got1.size(); k++) if (got1[k] !== exp_q1[k]) bad1++;
        chk_cnt++; if (got0.size() !== exp_q0.size() || bad0 !== 0) $display("FAIL b2b_payload0: %0d bytes %0d bad required %0d/0", got0.size(), bad0, exp_q0.size()); else pass_cnt++;
        chk_cnt++; if (got1.size() !== exp_q1.size() || bad1 !== 0) $display("FAIL b2b_payload1: %0d bytes %0d bad required %0d/0", got1.size(), bad1, exp_q1.size()); else pass_cnt++;
        chk_cnt++; if (hv_n[0] !== exp_hv[0] || hv_n[1] !== exp_hv[1]) $display("FAIL b2b_headers: got %0d/%0d required %0d/%0d", hv_n[0], hv_n[1], exp_hv[0], exp_hv[1]); else pass_cnt++;
        chk_cnt++; if (runt_n[0] !== exp_runt[0] || runt_n[1] !== exp_runt[1]) $display("FAIL b2b_runt: got %0d/%0d required %0d/%0d", runt_n[0], runt_n[1], exp_runt[0], exp_runt[1]); else pass_cnt++;
        chk_cnt++; if (len_n[0] !== exp_len[0] || len_n[1] !== exp_len[1]) $display("FAIL b2b_length: got %0d/%0d required %0d/%0d", len_n[0], len_n[1], exp_len[0], exp_len[1]); else pass_cnt++;
        chk_cnt++; if (dc0 !== exp_drop[0] || dc1 !== exp_drop[1]) $display("FAIL b2b_drop: got %0d/%0d required %0d/%0d", dc0, dc1, exp_drop[0], exp_drop[1]); else pass_cnt++;
        chk_cnt++; if (exp_hv[0] > 0 && (hdr_at[0] !== exp_hdr[0] || mm_at[0] !== exp_match[0])) $display("FAIL b2b_last_header: got %h/%b required %h/%b", hdr_at[0], mm_at[0], exp_hdr[0], exp_match[0]); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        build_frame(MY, 16'h0800, 46, 1'b1);
        for (int i = 0; i < 34; i++) begin
            in_data = frame_q[i]; in_valid = 1'b1; in_last = 1'b0;
            @(posedge clk); #1;
        end
        in_data = frame_q[34]; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        exp_drop[0] = 16'd0; exp_drop[1] = 16'd0;
        chk_cnt++; if ({hv0, mm0, ov0, ol0, er0, el0, ov1} !== 7'b0) $display("FAIL midreset_flags: got %b required 0", {hv0, mm0, ov0, ol0, er0, el0, ov1}); else pass_cnt++;
        chk_cnt++; if (od0 !== 8'h00 || dc0 !== 16'h0 || hdr0 !== '0) $display("FAIL midreset_state: data %h drop %0d hdr %h required 0", od0, dc0, hdr0); else pass_cnt++;
        clear_mon();
        build_frame(BCAST, 16'h0020, 46, 1'b0);
        send(1'b0);
        idle(4);
        for (int k = 0; k < exp_q0.size() && k < got0.size(); k++) if (got0[k] !== exp_q0[k]) bad++;
        chk_cnt++; if (hv_n[0] !== 1 || hdr_at[0] !== exp_hdr[0]) $display("FAIL midreset_reparse: pulses %0d hdr %h required 1 %h", hv_n[0], hdr_at[0], exp_hdr[0]); else pass_cnt++;
        chk_cnt++; if (got0.size() !== 46 || bad !== 0) $display("FAIL midreset_payload: %0d bytes %0d bad required 46/0", got0.size(), bad); else pass_cnt++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; reset = 1'b1;
        test_reset();
        test_unicast();
        test_filter();
        test_gaps();
        test_runt();
        test_length();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/eth_header_parse.md
# eth_header_parse

Receive-side counterpart of the Ethernet header generator. Consumes a byte-wide frame stream (preamble/SFD and FCS already stripped upstream) and captures destination MAC, source MAC and type/length into an `ethernet_header` struct. Filters on destination address and forwards accepted payload bytes downstream. Sits between the MAC receive front-end and the payload consumer.

## Interface
- `MY_MAC`, 48'he86a64e7e830: local station address; `[47:40]` is the first byte on the wire.
- `PROMISCUOUS`, 1'b0: when 1, every frame with a complete header is accepted.
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  8  frame byte.
- `in_valid`  in  1  `in_data` valid this cycle. There is no ready signal; every valid byte is consumed.
- `in_last`  in  1  marks the last byte of a frame; qualified by `in_valid`.
- `output_header`  out  ethernet_header  captured header. Byte index 0 of each field is the first byte received.
- `header_valid`  out  1  one-cycle pulse when a complete header has been captured.
- `mac_match`  out  1  destination-filter result; meaningful while `header_valid` is high.
- `out_data`  out  8  payload byte.
- `out_valid`  out  1  payload byte valid.
- `out_last`  out  1  last payload byte of the frame.
- `err_runt`  out  1  one-cycle pulse: the frame ended before 14 header bytes.
- `err_length`  out  1  one-cycle pulse: the length field is ≤ 1500 and fewer payload bytes arrived than it declares.
- `drop_count`  out  16  count of frames rejected by the filter; wraps at 2^16.

## Operation
- States:
  - HEADER: collecting bytes 0–13.
  - PAYLOAD: forwarding accepted payload.
  - DISCARD: dropping the rest of a rejected frame.
- HEADER:
  - Each valid byte is written into `output_header` at the index given by a 4-bit byte counter.
  - Bytes 0–5 go to `mac_destination`, 6–11 to `mac_source`, 12–13 to `eth_type_length`.
- On byte 13 accepted without `in_last`:
  - The filter accepts the frame if `PROMISCUOUS`, or destination == `MY_MAC`, or destination == 48'hffffffffffff.
  - Accepted frames go to PAYLOAD. Rejected frames go to DISCARD and increment `drop_count`.
- On byte 13 accepted with `in_last`:
  - The header is complete and the payload is empty.
  - Pulse `header_valid`.
  - If the frame is accepted, pulse `err_length` when the length field is between 1 and 1500 inclusive.
  - If the frame is rejected, increment `drop_count`.
  - Next state is HEADER.
- `in_last` on any of bytes 0–12:
  - Pulse `err_runt`; no `header_valid`.
  - Reset the byte counter to 0 and stay in HEADER.
- PAYLOAD:
  - Each valid byte is forwarded and increments an 11-bit payload counter that saturates at 2047.
  - On `in_last`: if the type/length value is ≤ 1500 and the count (including the last byte) is less than that value, pulse `err_length`. Then return to HEADER.
  - Excess bytes are padding and are not an error.
- DISCARD: no output; return to HEADER on a valid `in_last`.
- Cycles with `in_valid` low are ignored in every state; counters and state hold.
- `output_header` changes only while HEADER bytes arrive. It is stable from the `header_valid` pulse until byte 0 of the next frame.

## Timing
- Reset clears all of the following:
  - state to HEADER;
  - byte counter and payload counter to 0;
  - `output_header`, `header_valid`, `mac_match`, `out_data`, `out_valid`, `out_last`, `err_runt`, `err_length` and `drop_count` to 0.
- Reset mid-frame abandons that frame. The bytes following reset are parsed as a new header.
- `header_valid` and `mac_match` are registered and appear in the cycle after byte 13 is accepted.
- The `drop_count` increment becomes visible in that same cycle.
- Payload path latency is exactly 1 cycle. `out_*` registers `in_*` while in PAYLOAD; `out_valid` is 0 otherwise.
- `err_runt` and `err_length` assert in the cycle after the `in_last` byte.
- Back-to-back frames (byte 0 of the next frame directly after `in_last`) are supported with no idle cycle.

## Structure
- `ethernet_header`, `ETH_HEADER_BYTES` = 14, `ETH_MAX_LENGTH` = 1500 and `ETH_BROADCAST` belong in `ethernet_header_pkg`.
- The state enum is local to the module.
- One sub-module, `eth_mac_filter`: a combinational compare of the captured destination against `MY_MAC`, broadcast and `PROMISCUOUS`.

## Test plan
- Frame to `MY_MAC`, type 16'h0800, 46 payload bytes 0x00..0x2D:
  - `header_valid` pulses once with `mac_match` = 1.
  - 46 bytes emerge 1 cycle delayed, with `out_last` on 0x2D.
  - No errors.
- Frame to 48'he86a64e7e899 with `PROMISCUOUS` = 0:
  - `mac_match` = 0 and no `out_valid`.
  - `drop_count` goes 0 → 1.
  - Repeat the same frame with `PROMISCUOUS` = 1: accepted and forwarded.
- Broadcast destination with `in_valid` toggling every other cycle:
  - All payload bytes are forwarded in order; gaps are reproduced on `out_valid`.
- 10-byte frame ending in `in_last`: `err_runt` pulses, no `header_valid`. An immediately following valid frame parses correctly.
- Length field 16'h0040 (64) with only 50 payload bytes: `err_length` pulses after the last byte.
  - Length 16'h0020 with 46 bytes: no error.
- Assert `reset` at payload byte 20:
  - All outputs return to 0.
  - Next bytes are treated as header byte 0.
